// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared sizes and enums for the 4x4 keypad scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SCAN_NONE  = 2'd0,
        SCAN_KEY   = 2'd1,
        SCAN_MULTI = 2'd2
    } scan_kind_t;

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Keypad matrix pins plus the decoded key outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_COLS-1:0] COL;
    logic [NUM_ROWS-1:0] ROW;
    logic [3:0]          KEY_CODE;
    logic                KEY_VALID;
    logic                KEY_HELD;

    modport master (input COL, output ROW, output KEY_CODE, output KEY_VALID, output KEY_HELD);
    modport slave  (output COL, input ROW, input KEY_CODE, input KEY_VALID, input KEY_HELD);
endinterface
`default_nettype wire

// File: rtl/keypad_row_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_row_scan
//  Description : Column synchronizer, row rotation and per-scan key summary.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_row_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  wire logic                CLK,
    input  wire logic                RST_N,
    input  wire logic [NUM_COLS-1:0] i_col,
    output logic      [NUM_ROWS-1:0] o_row,
    output logic                     o_scan_done,
    output scan_kind_t               o_kind,
    output logic      [3:0]          o_key
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] c_div_last = DW'(SCAN_DIV - 1);

    logic [NUM_COLS-1:0] r_sync1, r_sync2;
    logic [DW-1:0]       r_div;
    logic [1:0]          r_row;
    logic [1:0]          r_zeros;   // zero bits seen so far this scan, saturating at 2
    logic [3:0]          r_key;
    logic                w_tc;
    logic [2:0]          w_row_zeros;
    logic [1:0]          w_col;
    logic [2:0]          w_tot;
    logic [1:0]          w_zeros_nxt;
    logic [3:0]          w_key_nxt;

    always_comb begin
        w_row_zeros = '0;
        w_col       = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!r_sync2[i]) begin
                w_row_zeros = w_row_zeros + 3'd1;
                w_col       = 2'(i);
            end
        end
        w_tot       = {1'b0, r_zeros} + w_row_zeros;
        w_zeros_nxt = (w_tot > 3'd2) ? 2'd2 : w_tot[1:0];
        w_key_nxt   = r_key;
        if (r_zeros == 2'd0 && w_row_zeros == 3'd1) begin
            w_key_nxt = {r_row, w_col};
        end
    end

    assign w_tc        = (r_div == c_div_last);
    assign o_scan_done = w_tc && (r_row == 2'(NUM_ROWS - 1));
    assign o_key       = w_key_nxt;
    assign o_row       = ~(NUM_ROWS'(1) << r_row);

    always_comb begin
        o_kind = SCAN_MULTI;
        if (w_zeros_nxt == 2'd0)      o_kind = SCAN_NONE;
        else if (w_zeros_nxt == 2'd1) o_kind = SCAN_KEY;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_div   <= '0;
            r_row   <= '0;
            r_zeros <= '0;
            r_key   <= '0;
        end else begin
            r_sync1 <= i_col;
            r_sync2 <= r_sync1;
            if (w_tc) begin
                r_div <= '0;
                r_row <= r_row + 2'd1;
                if (o_scan_done) begin
                    r_zeros <= '0;
                    r_key   <= '0;
                end else begin
                    r_zeros <= w_zeros_nxt;
                    r_key   <= w_key_nxt;
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 keypad scan, debounce FSM and key encoder.
//                Optional auto-repeat enabled by macro KEYPAD_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  wire logic         CLK,
    input  wire logic         RST_N,
    keypad_scanner_if.master  kp
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] c_ds  = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] c_one = CW'(1);

    if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    logic       w_done;
    scan_kind_t w_kind;
    logic [3:0] w_key;
    logic       w_is_key;
    logic       w_rep_hit;

    keypad_row_scan #(.SCAN_DIV(SCAN_DIV)) u_row_scan (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .i_col       (kp.COL),
        .o_row       (kp.ROW),
        .o_scan_done (w_done),
        .o_kind      (w_kind),
        .o_key       (w_key)
    );

    assign w_is_key = (w_kind == SCAN_KEY);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]    r_cand, w_cand_nxt;
    logic [3:0]    r_code, w_code_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_held, w_held_nxt;

    assign w_cnt_inc = (r_cnt == c_ds) ? r_cnt : r_cnt + c_one;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        w_held_nxt  = r_held;
        if (w_done) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_key) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            w_code_nxt  = w_key;
                            w_valid_nxt = 1'b1;
                            w_held_nxt  = 1'b1;
                            w_state_nxt = ST_PRESSED;
                        end else begin
                            w_cand_nxt  = w_key;
                            w_cnt_nxt   = c_one;
                            w_state_nxt = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_is_key) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else if (w_key != r_cand) begin
                        w_cand_nxt = w_key;
                        w_cnt_nxt  = c_one;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_ds) begin
                            w_code_nxt  = r_cand;
                            w_valid_nxt = 1'b1;
                            w_held_nxt  = 1'b1;
                            w_state_nxt = ST_PRESSED;
                        end
                    end
                end
                ST_PRESSED: begin
                    if (w_is_key) begin
                        w_valid_nxt = w_rep_hit;
                    end else if (DEBOUNCE_SCANS == 1) begin
                        w_held_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt   = c_one;
                        w_state_nxt = ST_RELEASE;
                    end
                end
                default: begin
                    if (w_is_key) begin
                        w_state_nxt = ST_PRESSED;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_ds) begin
                            w_held_nxt  = 1'b0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_held  <= w_held_nxt;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] r_rep, w_rep_inc, w_rep_target;
    logic          r_first;   // still waiting for the initial, longer delay

    assign w_rep_inc    = (r_rep == '1) ? r_rep : r_rep + RW'(1);
    assign w_rep_target = r_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
    assign w_rep_hit    = w_done && (r_state == ST_PRESSED) && w_is_key && (w_rep_inc >= w_rep_target);

    // Any scan end outside a continuing press restarts the delay.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rep   <= '0;
            r_first <= 1'b1;
        end else if (w_done) begin
            if (r_state != ST_PRESSED || !w_is_key) begin
                r_rep   <= '0;
                r_first <= 1'b1;
            end else if (w_rep_hit) begin
                r_rep   <= '0;
                r_first <= 1'b0;
            end else begin
                r_rep <= w_rep_inc;
            end
        end
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    assign kp.KEY_CODE  = r_code;
    assign kp.KEY_VALID = r_valid;
    assign kp.KEY_HELD  = r_held;

endmodule
`default_nettype wire
